counter_sched: RTL and testbench
================================

Name: counter_sched

Overview:
- Round-robin scheduler that shares one NBIT-bit count engine among NREQ requesters.
- Each requester supplies a length and a direction. The block grants the engine, sequences load/run/terminate, and returns a one-cycle done pulse to the owner.
- Sits between timing/sequencing clients and the shared counter datapath; replaces per-client counter instances.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NBIT, 8, counter and length width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req  input  NREQ  per-requester request level; held high until done or abort.
- dir  input  NREQ  per-requester direction, 1 = up, 0 = down; sampled at grant.
- len  input  NREQ*NBIT  per-requester length, slice i = len[i*NBIT +: NBIT]; sampled at grant.
- en  input  1  global count enable; 0 pauses RUN.
- gnt  output  NREQ  one-hot grant; all-zero when idle.
- busy  output  1  high in LOAD, RUN, DONE.
- cnt  output  NBIT  current engine value.
- done  output  NREQ  one-cycle completion pulse to the owner.

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE; gnt=0, busy=0, cnt=0, done=0.
  - RR pointer=0; latched dir/len cleared.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req is high, select the winner: first requester at or after the RR pointer, wrapping modulo NREQ.
  - Next edge: gnt=onehot(winner), latch dir/len of the winner, go to LOAD.
  - No req: stay in IDLE; cnt holds its last value.
- LOAD (1 cycle):
  - cnt <= 0 if up, len if down.
  - Terminal value is len if up, 0 if down.
  - Next state is RUN.
- RUN:
  - If cnt==terminal, go to DONE.
  - Else if en=1, cnt steps +1 (up) or -1 (down).
  - en=0 holds cnt; gnt is held.
- DONE (1 cycle):
  - done[winner]=1 and gnt held for this cycle.
  - RR pointer <= (winner+1) mod NREQ.
  - Next state is IDLE; gnt cleared on exit.
- Latency with en held high, len=L, grant edge at cycle k:
  - LOAD at k+1.
  - RUN from k+2 to k+2+L.
  - done at k+3+L.
- len=0:
  - LOAD, one RUN cycle (terminal met immediately), then DONE.
  - done at k+3.
- Arithmetic: cnt is NBIT unsigned with no wrap in normal use. Terminal is always reached first because len fits NBIT.
- Abort: owner drops req while in LOAD or RUN.
  - Next edge goes to IDLE, gnt=0, no done pulse.
  - RR pointer advances past the owner; cnt holds.
- req drop during DONE is ignored; done still pulses.
- dir/len changes after grant are ignored until the next grant.
- New requests during LOAD/RUN/DONE wait; arbitration happens only in IDLE.
- Back-to-back:
  - IDLE always lasts at least 1 cycle between grants, so gnt is low for 1 cycle.
  - done and a new gnt never coincide.
- rst asserted mid-operation: immediate return to reset values; no done pulse.
- Invariants: gnt is one-hot or zero; done is a subset of gnt; busy == (gnt != 0).

Optional Feature:
- Macro COUNTER_SCHED_FIXED_PRIO_EN.
  - Defined: the RR pointer is removed and the lowest-index active req always wins.
  - Undefined: round-robin as specified above.
- Ports and timing are identical in both builds.

Test Plan:
- Reset, then req=4'b0001, dir[0]=1, len[0]=5, en=1:
  - gnt=0001 one cycle after req.
  - cnt runs 0,1,2,3,4,5.
  - done[0] pulses 8 cycles after grant edge, then gnt=0.
- req=4'b0100, dir[2]=0, len[2]=3, en toggled 1/0 each cycle:
  - cnt steps 3,3,2,2,1,1,0 with pauses.
  - done[2] single pulse; cnt=0 after.
- req=4'b1111 held continuously, all len=1, up:
  - grant order 0,1,2,3,0.
  - Exactly 1 idle cycle between grants.
  - Each done pulses once per grant.
  - Repeat with COUNTER_SCHED_FIXED_PRIO_EN: requester 0 granted every time.
- len[1]=0, dir[1]=1:
  - LOAD, RUN, DONE.
  - done[1] at grant+3, cnt=0.
- Abort: req[3] granted with len=200 up; drop req[3] when cnt=10:
  - Next cycle gnt=0 and busy=0; no done[3].
  - Next grant goes to requester 0 if requesting.
- Async reset: assert rst=0 mid-RUN between clock edges:
  - Outputs clear immediately without a clock edge.
  - After release, requester 0 is the RR start point.

Source files
------------

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one NBIT count engine among NREQ requesters.
// Define COUNTER_SCHED_FIXED_PRIO_EN to use fixed lowest-index priority instead of round-robin.
module counter_sched #(
    parameter int NREQ = 4,
    parameter int NBIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      dir,
    input  logic [NREQ*NBIT-1:0] len,
    input  logic                 en,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic [NBIT-1:0]      cnt,
    output logic [NREQ-1:0]      done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            dir_q, dir_d;
    logic [NBIT-1:0] len_q, len_d;
    logic [NBIT-1:0] cnt_q, cnt_d;
    logic [NBIT-1:0] term;
    logic [PW-1:0]   win, cand;
    logic            found;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   ptr_next;
`endif

    // Winner search: scan NREQ slots starting at the pointer (or at 0 for fixed priority).
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
            cand = PW'(i);
`else
            cand = PW'((32'(ptr_q) + i) % NREQ);
`endif
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign term = dir_q ? len_q : '0;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
    assign ptr_next = PW'((32'(owner_q) + 1) % NREQ);
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        dir_d   = dir_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_LOAD;
                    owner_d = win;
                    dir_d   = dir[win];
                    len_d   = len[win*NBIT +: NBIT];
                end
            end
            S_LOAD, S_RUN: begin
                // Owner withdrawal wins over load, step and terminal detection; cnt holds.
                if (!req[owner_q]) begin
                    state_d = S_IDLE;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
                    ptr_d   = ptr_next;
`endif
                end else if (state_q == S_LOAD) begin
                    state_d = S_RUN;
                    cnt_d   = dir_q ? '0 : len_q;
                end else if (cnt_q == term) begin
                    state_d = S_DONE;
                end else if (en) begin
                    cnt_d = dir_q ? cnt_q + 1'b1 : cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
                ptr_d   = ptr_next;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            dir_q   <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
`ifndef COUNTER_SCHED_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        gnt  = busy ? (NREQ'(1) << owner_q) : '0;
        done = (state_q == S_DONE) ? gnt : '0;
        cnt  = cnt_q;
    end

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched: per-cycle transaction model plus directed literal checks.
module tb_counter_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   dir;
    logic [N*W-1:0] len;
    logic           en;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [W-1:0]   cnt;
    logic [N-1:0]   done;

    int n_cmp = 0;
    int n_bad = 0;

    counter_sched #(.NREQ(N), .NBIT(W)) dut (
        .clk(clk), .rst(rst), .req(req), .dir(dir), .len(len), .en(en),
        .gnt(gnt), .busy(busy), .cnt(cnt), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Transaction model: owner index, cycles since grant, steps taken, finished flag.
    int m_owner, m_ptr, m_cnt, m_L, m_t, m_steps;
    bit m_up, m_fin;

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
            if (r[k]) return k;
`else
            if (r[(ptr + k) % N]) return (ptr + k) % N;
`endif
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner <= -1; m_ptr <= 0; m_cnt <= 0; m_fin <= 1'b0;
            m_t <= 0; m_steps <= 0; m_L <= 0; m_up <= 1'b0;
        end else if (m_owner < 0) begin
            if (pick(req, m_ptr) >= 0) begin
                m_owner <= pick(req, m_ptr);
                m_L     <= int'(len[pick(req, m_ptr)*W +: W]);
                m_up    <= dir[pick(req, m_ptr)];
                m_t <= 0; m_steps <= 0; m_fin <= 1'b0;
            end
        end else if (m_fin) begin
            m_ptr <= (m_owner + 1) % N; m_owner <= -1; m_fin <= 1'b0;
        end else if (!req[m_owner]) begin
            m_ptr <= (m_owner + 1) % N; m_owner <= -1;
        end else if (m_t == 0) begin
            m_cnt <= m_up ? 0 : m_L; m_t <= 1;
        end else if (m_steps == m_L) begin
            m_fin <= 1'b1;
        end else if (en) begin
            m_steps <= m_steps + 1;
            m_cnt   <= m_up ? m_steps + 1 : m_L - m_steps - 1;
        end
    end

    always @(negedge clk) begin
        int eg;
        eg = (m_owner >= 0) ? (1 << m_owner) : 0;
        check("model_gnt", int'(gnt), eg);
        check("model_busy", int'(busy), (m_owner >= 0) ? 1 : 0);
        check("model_cnt", int'(cnt), m_cnt);
        check("model_done", int'(done), m_fin ? eg : 0);
    end

    int tr [100];
    int t_done, n_busy, n_done;

    function automatic int oh2i(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one transaction from the current negedge; sample 0 is the first cycle gnt is visible.
    task automatic run_txn(input int owner, input bit toggle_en);
        int s;
        t_done = -1; n_busy = 0; n_done = 0;
        for (int c = 0; c < 20 && gnt == '0; c++) @(negedge clk);
        if (gnt == '0) begin
            check("grant_timeout", 0, 1);
            return;
        end
        check("grant_onehot", int'(gnt), 1 << owner);
        s = 0;
        while (busy && s < 100) begin
            tr[s] = int'(cnt);
            if (done != '0) begin
                n_done++;
                t_done = s;
                req[owner] = 1'b0;
            end
            if (toggle_en) en = ~en;
            @(negedge clk);
            s++;
        end
        if (s >= 100) check("txn_timeout", 0, 1);
        n_busy = s;
    endtask

    initial begin
        int order [5];
        int ndone [5];
        int exp_order [5];
        int gcount, zero_run, seen_d3;
        logic [N-1:0] prev;

        rst = 1'b0; req = '0; dir = '0; len = '0; en = 1'b1;
        @(negedge clk);
        check("reset_gnt", int'(gnt), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_cnt", int'(cnt), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b1;
        @(negedge clk);

        // Up count of 5 on requester 0: owner registers done on the 8th edge after grant.
        dir[0] = 1'b1; len[0*W +: W] = 8'd5; req = 4'b0001;
        run_txn(0, 1'b0);
        check("t1_done_edge", t_done + 1, 8);
        check("t1_cnt_after_load", tr[1], 0);
        check("t1_cnt_s6", tr[6], 5);
        check("t1_busy_cycles", n_busy, 8);
        check("t1_done_count", n_done, 1);
        check("t1_gnt_after", int'(gnt), 0);

        // Down count of 3 with en toggling each cycle.
        dir[2] = 1'b0; len[2*W +: W] = 8'd3; req = 4'b0100;
        run_txn(2, 1'b1);
        en = 1'b1;
        check("t2_cnt_after_load", tr[1], 3);
        check("t2_done_count", n_done, 1);
        check("t2_cnt_final", int'(cnt), 0);

        // All requesting, len=1 up: fairness and the mandatory idle cycle.
        do_reset();
        dir = 4'b1111; len = {8'd1, 8'd1, 8'd1, 8'd1}; req = 4'b1111;
`ifdef COUNTER_SCHED_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        gcount = 0; zero_run = 0; prev = '0;
        for (int k = 0; k < 5; k++) ndone[k] = 0;
        for (int c = 0; c < 60 && gcount < 5; c++) begin
            @(negedge clk);
            if (gnt == '0) zero_run++;
            else if (prev == '0) begin
                order[gcount] = oh2i(gnt);
                if (gcount > 0) check("t3_idle_gap", zero_run, 1);
                zero_run = 0;
                gcount++;
            end
            if (done != '0 && gcount > 0) ndone[gcount-1]++;
            prev = gnt;
        end
        check("t3_grants", gcount, 5);
        for (int k = 0; k < 5; k++) check("t3_order", order[k], exp_order[k]);
        for (int k = 0; k < 4; k++) check("t3_done_per_grant", ndone[k], 1);
        req = '0;
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        check("t3_drain", int'(busy), 0);

        // Zero length: LOAD, one RUN, DONE.
        dir[1] = 1'b1; len[1*W +: W] = 8'd0; req = 4'b0010;
        run_txn(1, 1'b0);
        check("t4_done_edge", t_done + 1, 3);
        check("t4_busy_cycles", n_busy, 3);
        check("t4_cnt_at_done", tr[2], 0);

        // Abort of requester 3 at cnt=10; pointer must move on to 0 even with 3 requesting again.
        dir[3] = 1'b1; len[3*W +: W] = 8'd200; dir[0] = 1'b1; len[0*W +: W] = 8'd2;
        req = 4'b1000; seen_d3 = 0;
        for (int c = 0; c < 40 && !(busy && cnt == 8'd10); c++) @(negedge clk);
        check("t5_reach10", int'(cnt), 10);
        req = 4'b0001;
        @(negedge clk);
        check("t5_gnt_abort", int'(gnt), 0);
        check("t5_busy_abort", int'(busy), 0);
        check("t5_cnt_hold", int'(cnt), 10);
        req = 4'b1001;
        @(negedge clk);
        check("t5_next_grant", int'(gnt), 1);
        for (int c = 0; c < 20 && busy; c++) begin
            if (done[3]) seen_d3++;
            if (done[0]) req = 4'b0000;
            @(negedge clk);
        end
        check("t5_no_done3", seen_d3, 0);
        check("t5_drain", int'(busy), 0);

        // Async reset mid-RUN, then requester 0 must win from a full request set.
        dir[2] = 1'b1; len[2*W +: W] = 8'd50; req = 4'b0100;
        for (int c = 0; c < 40 && !(busy && cnt == 8'd5); c++) @(negedge clk);
        check("t6_reach5", int'(cnt), 5);
        check("t6_owner", int'(gnt), 4);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_async_gnt", int'(gnt), 0);
        check("t6_async_busy", int'(busy), 0);
        check("t6_async_cnt", int'(cnt), 0);
        check("t6_async_done", int'(done), 0);
        req = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rr_start", int'(gnt), 1);
        req = '0;
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
